mem_port_arbiter: RTL and testbench

- Shares the single data-memory system (cache + four-bank memory) between two requesters: instruction fetch (I port) and the memory stage (D port).
- Data requests have fixed priority. A starvation counter forces an instruction grant after STARVE_LIMIT consecutive data grants.
- Unaligned requests are rejected locally and never reach memory.
- Per-requester done/stall/err are generated here so the fetch and memory stages can freeze the pipeline.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory system (cache + banked memory) between instruction fetch
// (I port) and the memory stage (D port). Data requests have fixed priority,
// but a starvation counter forces an instruction grant after STARVE_LIMIT
// consecutive data grants while fetch is waiting. Unaligned requests are
// rejected locally and never reach memory.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   i_req, i_addr             fetch read request (held until i_done)
//   i_rdata, i_done, i_stall, i_err   fetch completion / freeze / error
//   d_rd, d_wr, d_addr, d_wdata       load/store request (held until d_done)
//   d_rdata, d_done, d_stall, d_err   memory-stage completion / freeze / error
//   mem_addr, mem_wdata, mem_rd, mem_wr          command to mem_system
//   mem_rdata, mem_done, mem_stall, mem_err      response from mem_system
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;

  logic        d_req, starved, grant_i, grant_d;
  logic [15:0] mem_addr_c, mem_wdata_c, i_rdata_c, d_rdata_c;
  logic        mem_rd_c, mem_wr_c, i_done_c, i_err_c, d_done_c, d_err_c;

  assign d_req   = d_rd | d_wr;
  assign starved = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Grants happen only from IDLE while memory is not stalled. Fetch wins when
  // data is idle, or when both are pending and fetch has waited long enough.
  assign grant_i = (state_q == IDLE) & ~mem_stall & i_req & (~d_req | starved);
  assign grant_d = (state_q == IDLE) & ~mem_stall & d_req & ~grant_i;

  // State register plus the latched address/data that is held on the memory
  // bus while a transfer is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and output logic. Unaligned winners complete with an error in
  // the grant cycle without touching memory, and stay in IDLE. In BUSY the
  // done pulse is suppressed if the requester has already dropped its request,
  // but the transfer itself still runs to completion.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    i_done_c    = 1'b0;
    i_err_c     = 1'b0;
    i_rdata_c   = '0;
    d_done_c    = 1'b0;
    d_err_c     = 1'b0;
    d_rdata_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          if (d_addr[0]) begin
            d_done_c = 1'b1;
            d_err_c  = 1'b1;
          end else begin
            mem_addr_c  = d_addr;
            mem_wdata_c = d_wdata;
            mem_wr_c    = d_wr;
            mem_rd_c    = ~d_wr;
            addr_d      = d_addr;
            wdata_d     = d_wdata;
            state_d     = BUSY_D;
          end
        end else if (grant_i) begin
          if (i_addr[0]) begin
            i_done_c = 1'b1;
            i_err_c  = 1'b1;
          end else begin
            mem_addr_c  = i_addr;
            mem_wdata_c = '0;
            mem_rd_c    = 1'b1;
            addr_d      = i_addr;
            wdata_d     = '0;
            state_d     = BUSY_I;
          end
        end
      end
      BUSY_D: begin
        if (mem_done) begin
          d_done_c  = d_req;
          d_err_c   = d_req & mem_err;
          d_rdata_c = d_req ? mem_rdata : '0;
          state_d   = IDLE;
        end else if (mem_err) begin
          d_done_c = d_req;
          d_err_c  = d_req;
          state_d  = DRAIN;
        end
      end
      BUSY_I: begin
        if (mem_done) begin
          i_done_c  = i_req;
          i_err_c   = i_req & mem_err;
          i_rdata_c = i_req ? mem_rdata : '0;
          state_d   = IDLE;
        end else if (mem_err) begin
          i_done_c = i_req;
          i_err_c  = i_req;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: counts data grants that happened while fetch waited.
  // Unaligned grants count too. Any cycle without a fetch request clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_req || grant_i) begin
      cnt_d = '0;
    end else if (grant_d && (cnt_q < CNT_W'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // While reset is asserted every output is forced quiet, even though the
  // state register only clears at the clock edge.
  assign mem_addr  = rst ? mem_addr_c  : '0;
  assign mem_wdata = rst ? mem_wdata_c : '0;
  assign mem_rd    = rst & mem_rd_c;
  assign mem_wr    = rst & mem_wr_c;
  assign i_done    = rst & i_done_c;
  assign i_err     = rst & i_err_c;
  assign i_rdata   = rst ? i_rdata_c : '0;
  assign d_done    = rst & d_done_c;
  assign d_err     = rst & d_err_c;
  assign d_rdata   = rst ? d_rdata_c : '0;
  assign i_stall   = rst & i_req & ~i_done_c;
  assign d_stall   = rst & d_req & ~d_done_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of single-transfer vectors plus
// hand-written sequences for reset, latency, starvation, memory error with
// drain, and reset in the middle of a transfer.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done, i_stall, i_err;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_stall, d_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        dRd, dWr;
    logic [15:0] dAddr, dWdata;
    logic        iReq;
    logic [15:0] iAddr;
    logic        mStall;
    logic        eRd, eWr;
    logic [15:0] eAddr, eWdata;
    logic        eDDone, eDErr, eIDone, eIErr;
  } vec_t;

  vec_t vecs [10];

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_done(i_done), .i_stall(i_stall), .i_err(i_err),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    i_req = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    d_rd = v.dRd; d_wr = v.dWr; d_addr = v.dAddr; d_wdata = v.dWdata;
    i_req = v.iReq; i_addr = v.iAddr; mem_stall = v.mStall;
    mem_done = 1'b0; mem_err = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    int grants;
    logic winD, issued;

    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0,
                1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 16'h0000, 1'b0,
                1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0044, 16'h5555, 1'b0, 16'h0000, 1'b0,
                1'b0, 1'b1, 16'h0044, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 1'b0,
                1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0200, 1'b0,
                1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0021, 16'h9999, 1'b0, 16'h0000, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0301, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0400, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0402, 1'b1,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held for two cycles with both requesters pending.
    rst = 1'b0;
    idleInputs();
    d_rd = 1'b1; d_addr = 16'h0008; i_req = 1'b1; i_addr = 16'h0100;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      checkOutput("rst.memRd", mem_rd, 1'b0);
      checkOutput("rst.memWr", mem_wr, 1'b0);
      checkOutput("rst.memAddr", mem_addr, 16'h0000);
      checkOutput("rst.dDone", d_done, 1'b0);
      checkOutput("rst.iDone", i_done, 1'b0);
      checkOutput("rst.dStall", d_stall, 1'b0);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstRel.memRd", mem_rd, 1'b1);
    checkOutput("rstRel.memAddr", mem_addr, 16'h0008);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    checkOutput("rstRel.dDone", d_done, 1'b1);
    checkOutput("rstRel.iDone", i_done, 1'b0);
    tick();
    idleInputs();
    tick();

    // Single load with a three-cycle memory latency.
    d_rd = 1'b1; d_addr = 16'h0010;
    @(negedge clk);
    checkOutput("load.memRd", mem_rd, 1'b1);
    checkOutput("load.memAddr", mem_addr, 16'h0010);
    checkOutput("load.dStall0", d_stall, 1'b1);
    for (int c = 1; c < 3; c++) begin
      tick();
      @(negedge clk);
      checkOutput("load.memRdBusy", mem_rd, 1'b0);
      checkOutput("load.memAddrHeld", mem_addr, 16'h0010);
      checkOutput("load.dStallBusy", d_stall, 1'b1);
      checkOutput("load.dDoneBusy", d_done, 1'b0);
    end
    tick();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    checkOutput("load.dDone", d_done, 1'b1);
    checkOutput("load.dRdata", d_rdata, 16'hBEEF);
    checkOutput("load.dStallDone", d_stall, 1'b0);
    checkOutput("load.iDone", i_done, 1'b0);
    tick();
    idleInputs();
    @(negedge clk);
    checkOutput("load.dRdataAfter", d_rdata, 16'h0000);
    tick();

    // Table of single transfers, each starting from IDLE with the counter clear.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      issued = vecs[i].eRd | vecs[i].eWr;
      winD   = vecs[i].dRd | vecs[i].dWr;
      @(negedge clk);
      checkOutput($sformatf("vec%0d.memRd", i), mem_rd, vecs[i].eRd);
      checkOutput($sformatf("vec%0d.memWr", i), mem_wr, vecs[i].eWr);
      checkOutput($sformatf("vec%0d.dDone", i), d_done, vecs[i].eDDone);
      checkOutput($sformatf("vec%0d.dErr", i), d_err, vecs[i].eDErr);
      checkOutput($sformatf("vec%0d.iDone", i), i_done, vecs[i].eIDone);
      checkOutput($sformatf("vec%0d.iErr", i), i_err, vecs[i].eIErr);
      if (issued) begin
        checkOutput($sformatf("vec%0d.memAddr", i), mem_addr, vecs[i].eAddr);
        checkOutput($sformatf("vec%0d.memWdata", i), mem_wdata, vecs[i].eWdata);
      end
      tick();
      if (issued) begin
        mem_done = 1'b1; mem_rdata = 16'hA500 | 16'(i);
        @(negedge clk);
        if (winD) begin
          checkOutput($sformatf("vec%0d.cplDDone", i), d_done, 1'b1);
          checkOutput($sformatf("vec%0d.cplDRdata", i), d_rdata, 16'hA500 | 16'(i));
          checkOutput($sformatf("vec%0d.cplIDone", i), i_done, 1'b0);
        end else begin
          checkOutput($sformatf("vec%0d.cplIDone", i), i_done, 1'b1);
          checkOutput($sformatf("vec%0d.cplIRdata", i), i_rdata, 16'hA500 | 16'(i));
          checkOutput($sformatf("vec%0d.cplDDone", i), d_done, 1'b0);
        end
        tick();
      end
      idleInputs();
      tick();
    end

    // Contention: four data grants, then a forced fetch grant, then the cycle
    // repeats because the counter was cleared.
    d_rd = 1'b1; d_addr = 16'h0030; i_req = 1'b1; i_addr = 16'h0400;
    mem_done = 1'b1; mem_rdata = 16'h7777;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
      @(negedge clk);
      if (mem_rd) begin
        checkOutput($sformatf("starve.grant%0d", grants), mem_addr,
                    (grants == 4 || grants == 9) ? 16'h0400 : 16'h0030);
        grants++;
      end
      tick();
    end
    checkOutput("starve.grantCount", 16'(grants), 16'd10);
    d_rd = 1'b0; i_req = 1'b0;
    tick();
    idleInputs();
    tick();

    // Memory error on a fetch, followed by a stalled drain with data waiting.
    i_req = 1'b1; i_addr = 16'h0500;
    @(negedge clk);
    checkOutput("err.memRd", mem_rd, 1'b1);
    checkOutput("err.memAddr", mem_addr, 16'h0500);
    tick();
    mem_err = 1'b1; mem_stall = 1'b1; d_rd = 1'b1; d_addr = 16'h0050;
    @(negedge clk);
    checkOutput("err.iDone", i_done, 1'b1);
    checkOutput("err.iErr", i_err, 1'b1);
    checkOutput("err.dDone", d_done, 1'b0);
    tick();
    i_req = 1'b0; mem_err = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("err.noGrantStall", mem_rd, 1'b0);
      tick();
    end
    mem_stall = 1'b0;
    @(negedge clk);
    checkOutput("err.noGrantDrain", mem_rd, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("err.grantAfter", mem_rd, 1'b1);
    checkOutput("err.grantAddr", mem_addr, 16'h0050);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h2222;
    @(negedge clk);
    checkOutput("err.dDoneAfter", d_done, 1'b1);
    checkOutput("err.dRdataAfter", d_rdata, 16'h2222);
    tick();
    idleInputs();
    tick();

    // Reset while a data transfer is in flight.
    d_rd = 1'b1; d_addr = 16'h0060;
    @(negedge clk);
    checkOutput("midRst.issue", mem_rd, 1'b1);
    tick();
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h3333;
    @(negedge clk);
    checkOutput("midRst.dDone", d_done, 1'b0);
    checkOutput("midRst.memRd", mem_rd, 1'b0);
    tick();
    rst = 1'b1; mem_done = 1'b0;
    @(negedge clk);
    checkOutput("midRst.reissue", mem_rd, 1'b1);
    checkOutput("midRst.reissueAddr", mem_addr, 16'h0060);
    checkOutput("midRst.dDoneIdle", d_done, 1'b0);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h4444;
    @(negedge clk);
    checkOutput("midRst.dDoneFinal", d_done, 1'b1);
    checkOutput("midRst.dRdataFinal", d_rdata, 16'h4444);
    tick();
    idleInputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
